// File: rtl/ram_16x8.sv
// ram_16x8 -- main memory for the 8-bit CPU.
// 16 x 8 word store. It is loaded from the bus and drives the selected word
// onto the bus. In manual mode it is programmed from the front-panel switches
// through a synchronised, debounced write button. After every reset it zeroes
// all locations (busy=1) before it accepts any access.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   address           word select (from MAR)
//   read_from_bus     store bus_in into mem[address] at the next edge
//   write_to_bus      drive mem[address] onto the bus
//   bus_in            bus value
//   bus_out           mem[address] when bus_drive is high, else 0
//   bus_drive         bus output enable
//   manual_mode       front-panel programming mode
//   manual_write      raw, asynchronous write button
//   manual_data       data switches
//   data_out          mem[address] for the LEDs (0 while busy)
//   busy              self-clear in progress
module ram_16x8 #(
  parameter int WIDTH           = 8,
  parameter int ADDR_BITS       = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 read_from_bus,
  input  logic                 write_to_bus,
  input  logic [WIDTH-1:0]     bus_in,
  output logic [WIDTH-1:0]     bus_out,
  output logic                 bus_drive,
  input  logic                 manual_mode,
  input  logic                 manual_write,
  input  logic [WIDTH-1:0]     manual_data,
  output logic [WIDTH-1:0]     data_out,
  output logic                 busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]        CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]        CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] ptr;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 s1, s2;
  logic [CW-1:0]        cnt;
  logic                 man_fire, bus_we, man_we;
  logic [WIDTH-1:0]     rd_word;

  // ---- self-clear FSM ----
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= CLEAR;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == PTR_LAST) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)                ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;

  assign busy = (state == CLEAR);

  // ---- manual button: 2-flop synchroniser + saturating debounce counter ----
  // The counter keeps running regardless of mode/busy so that a press that
  // completes while writes are disallowed is consumed rather than deferred.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= manual_write;
      s2 <= s1;
      if (!s2)                cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end

  // Single-cycle strobe on the D-1 -> D transition; saturation stops repeats.
  assign man_fire = s2 && (cnt == CNT_FIRE);

  assign bus_we = read_from_bus && !manual_mode && !busy;
  assign man_we = man_fire && manual_mode && !busy;

  // ---- storage (no reset; zeroed by the CLEAR sweep) ----
  always_ff @(posedge clk)
    if (busy)        mem[ptr]     <= '0;
    else if (bus_we) mem[address] <= bus_in;
    else if (man_we) mem[address] <= manual_data;

  // ---- read side: combinational, returns the pre-edge word ----
  assign rd_word   = mem[address];
  assign bus_drive = write_to_bus && !manual_mode && !busy;
  assign bus_out   = bus_drive ? rd_word : '0;
  assign data_out  = busy ? '0 : rd_word;

endmodule

// File: tb/tb_ram_16x8.sv
// tb_ram_16x8 -- randomized + directed bench for ram_16x8 against a
// behavioural model (word array, clear-edge countdown, button sample history).
module tb_ram_16x8;
  localparam int W = 8, AB = 4, D = 4, DEPTH = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic [AB-1:0] address = '0;
  logic          read_from_bus = 1'b0, write_to_bus = 1'b0;
  logic [W-1:0]  bus_in = '0, manual_data = '0;
  logic          manual_mode = 1'b0, manual_write = 1'b0;
  logic [W-1:0]  bus_out, data_out;
  logic          bus_drive, busy;

  ram_16x8 #(.WIDTH(W), .ADDR_BITS(AB), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .address(address),
    .read_from_bus(read_from_bus), .write_to_bus(write_to_bus),
    .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
    .manual_mode(manual_mode), .manual_write(manual_write),
    .manual_data(manual_data), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference model
  logic [W-1:0] mem_m [DEPTH];
  int           clr_left;     // clear edges still to come
  logic [D+2:0] hist;         // raw button value at each edge, bit0 = newest
  int           n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_out();
    logic bd;
    bd = write_to_bus && !manual_mode && (clr_left == 0);
    check("busy",      32'(busy),      32'(clr_left > 0));
    check("data_out",  32'(data_out),  (clr_left > 0) ? 32'h0 : 32'(mem_m[address]));
    check("bus_drive", 32'(bus_drive), 32'(bd));
    check("bus_out",   32'(bus_out),   bd ? 32'(mem_m[address]) : 32'h0);
  endtask

  // One clock edge: advance the model from the inputs present at the edge.
  // A press is accepted on the edge where the button has been seen high at
  // D consecutive edges ending two edges ago (synchroniser delay), having
  // been low just before that run.
  task automatic tick();
    logic fire;
    @(posedge clk);
    hist = {hist[D+1:0], manual_write};
    fire = (&hist[D+1:2]) && !hist[D+2];
    if (clr_left > 0)                          clr_left--;
    else if (read_from_bus && !manual_mode)    mem_m[address] = bus_in;
    else if (manual_mode && fire)              mem_m[address] = manual_data;
    #1 check_out();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_busy",      32'(busy),      32'h1);
    check("rst_bus_drive", 32'(bus_drive), 32'h0);
    check("rst_bus_out",   32'(bus_out),   32'h0);
    check("rst_data_out",  32'(data_out),  32'h0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    clr_left = DEPTH;
    hist     = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic quiet();
    read_from_bus = 0; write_to_bus = 0; manual_mode = 0; manual_write = 0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      address = AB'(a);
      #1 check(tag, 32'(data_out), 32'h0);
    end
  endtask

  initial begin
    // first clear
    do_reset();
    repeat (DEPTH) tick();

    // preload garbage, then reset, pulse reset at clear step 7, clear again
    read_from_bus = 1;
    for (int a = 0; a < DEPTH; a++) begin
      address = AB'(a); bus_in = W'($urandom_range(1, 255));
      tick();
    end
    read_from_bus = 0;
    do_reset();
    repeat (7) tick();
    do_reset();
    repeat (DEPTH - 1) tick();
    check("busy_at_edge15", 32'(busy), 32'h1);
    tick();
    check("busy_after_16", 32'(busy), 32'h0);
    read_all_zero("clear_data");

    // bus write / read
    read_from_bus = 1;
    address = 4'd3;  bus_in = 8'hA5; tick();
    address = 4'd15; bus_in = 8'h3C; tick();
    read_from_bus = 0; write_to_bus = 1;
    address = 4'd3;  #1 check("rd3", 32'(bus_out), 32'hA5);
    check("rd3_drive", 32'(bus_drive), 32'h1);
    address = 4'd15; #1 check("rd15", 32'(bus_out), 32'h3C);
    address = 4'd4;  #1 check("rd4", 32'(bus_out), 32'h00);
    // simultaneous read+write: old word now, new word after the edge
    address = 4'd3; read_from_bus = 1; bus_in = 8'h11;
    #1 check("rw_old", 32'(bus_out), 32'hA5);
    tick();
    check("rw_new", 32'(bus_out), 32'h11);
    quiet(); tick();

    // manual write latency and single write per press
    manual_mode = 1; address = 4'd9; manual_data = 8'h7E; manual_write = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) check("man_pre_edge6", 32'(data_out), 32'h00);
      if (i == 5) begin
        check("man_edge6", 32'(data_out), 32'h7E);
        manual_data = 8'h55;
      end
    end
    manual_write = 0; repeat (4) tick();
    check("man_once", 32'(data_out), 32'h7E);

    // debounce reject: 3 high samples
    address = 4'd10; manual_data = 8'h99; manual_write = 1;
    repeat (3) tick();
    manual_write = 0; repeat (8) tick();
    check("deb_reject", 32'(data_out), 32'h00);

    // mode interlock
    address = 4'd2; read_from_bus = 1; write_to_bus = 1; bus_in = 8'hFF;
    #1 check("mode_drive", 32'(bus_drive), 32'h0);
    check("mode_bus_out", 32'(bus_out), 32'h0);
    tick();
    check("mode_no_write", 32'(data_out), 32'h00);
    read_from_bus = 0; write_to_bus = 0; manual_mode = 0; manual_data = 8'hC3;
    manual_write = 1; repeat (8) tick();
    manual_write = 0; manual_mode = 1; repeat (6) tick();
    check("press_discard", 32'(data_out), 32'h00);
    quiet();

    // busy interlock
    do_reset();
    address = 4'd5; bus_in = 8'hEE; read_from_bus = 1;
    repeat (6) tick();
    read_from_bus = 0; manual_mode = 1; manual_data = 8'hDD; manual_write = 1;
    repeat (8) tick();
    manual_write = 0; repeat (4) tick();
    quiet();
    check("busy_still", 32'(busy), 32'h0);
    read_all_zero("busy_interlock");

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      address       = AB'($urandom);
      read_from_bus = ($urandom_range(0, 3) == 0);
      write_to_bus  = $urandom_range(0, 1) == 1;
      bus_in        = W'($urandom);
      manual_data   = W'($urandom);
      if ($urandom_range(0, 19) == 0) manual_mode  = ~manual_mode;
      if ($urandom_range(0, 4)  == 0) manual_write = ~manual_write;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_16x8.md
# ram_16x8

Main memory for the 8-bit CPU: 16 words of 8 bits, addressed by the 4-bit memory address register output. It loads words from the bus and drives the selected word onto the bus under control-word signals. In manual mode it is programmed from front-panel switches through a synchronised, debounced write button. After every reset it runs a self-clear sequence that zeroes all locations before it accepts any access.

## Interface
- WIDTH, 8: data word width.
- ADDR_BITS, 4: address width; depth = 2**ADDR_BITS.
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high cycles needed to accept a manual write press (≥1).

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- address  in  ADDR_BITS  word select (from MAR).
- read_from_bus  in  1  store bus_in into mem[address] at the next edge.
- write_to_bus  in  1  drive mem[address] onto the bus.
- bus_in  in  WIDTH  bus value.
- bus_out  out  WIDTH  mem[address] when bus_drive is high, else 0.
- bus_drive  out  1  bus output enable.
- manual_mode  in  1  front-panel programming mode.
- manual_write  in  1  raw, asynchronous write button.
- manual_data  in  WIDTH  data switches.
- data_out  out  WIDTH  mem[address] at all times, for LEDs (0 while busy).
- busy  out  1  self-clear in progress.

## Operation
- FSM states: CLEAR, IDLE.
- Reset: state=CLEAR, clear pointer=0, synchroniser flops=0, debounce counter=0, busy=1, bus_drive=0, bus_out=0, data_out=0. Memory contents are not reset asynchronously.
- CLEAR: on each edge, write mem[ptr] <= 0 and increment ptr. After the write to location 15 (2**ADDR_BITS-1), go to IDLE. busy=1 throughout. Bus and manual writes are ignored. Reset asserted mid-clear restarts the sequence at ptr=0.
- IDLE: busy=0.
- Bus write: read_from_bus && !manual_mode && !busy. mem[address] <= bus_in on the edge.
- Bus read: bus_drive = write_to_bus && !manual_mode && !busy. It is combinational from the current address and memory. When read_from_bus and write_to_bus are both asserted, the read returns the old word and the write commits at the edge.
- Manual path: manual_write passes through a 2-flop synchroniser to give s2. The counter increments while s2=1, saturating at DEBOUNCE_CYCLES, and clears to 0 on any cycle with s2=0.
- The manual write fires on the edge where the counter goes from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES, and only if manual_mode && !busy. It performs mem[address] <= manual_data.
- Exactly one write per press. A held button does not repeat. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles causes no write.
- The counter runs even outside manual mode or during CLEAR. A press that completes while disallowed is discarded, not deferred.
- manual_mode has priority: it suppresses both bus read and bus write.
- Simultaneous bus write and manual write cannot both occur, because they are mutually exclusive on manual_mode.
- Address wraps naturally at ADDR_BITS. Out-of-range addresses cannot occur.

## Timing
- CLEAR lasts 2**ADDR_BITS edges after rst deasserts. busy falls after edge 16, so the first access is accepted at edge 17.
- Bus write: data is visible on data_out and bus_out in the cycle after the edge.
- Bus read: zero-cycle latency, combinational from address, write_to_bus and manual_mode.
- Manual write: with manual_write rising before edge 1, s2 is high after edge 2. The write commits at edge 2+DEBOUNCE_CYCLES (edge 6 by default) and is visible after it.
- No outputs depend on manual_write combinationally.

## Test plan
- Reset then clear: preload garbage via bus, assert rst, release. Required: busy=1 for 16 edges, then 0; every address reads 0x00 on data_out. Pulse rst at clear step 7: sequence restarts, busy lasts 16 more edges.
- Bus write/read: after clear, write 0xA5 to addr 3 and 0x3C to addr 15, then read both with write_to_bus=1. Required: bus_out=0xA5 and 0x3C, bus_drive=1, other addresses still 0x00.
- Manual write latency: manual_mode=1, address=9, manual_data=0x7E, hold manual_write high 10 cycles. Required: mem[9]=0x7E after edge 6 (not before), and exactly one write, checked by changing manual_data after edge 6 with mem[9] still 0x7E.
- Debounce reject: manual_write high for 3 synchronised cycles, then low. Required: no memory change.
- Mode interlock: manual_mode=1 with read_from_bus=1, bus_in=0xFF, write_to_bus=1. Required: no write, bus_drive=0, bus_out=0. A press completing while manual_mode=0 is discarded.
- Busy interlock: a bus write and a completed manual press during CLEAR. Required: all locations 0x00 after busy falls.
